// File: rtl/mor1kx_muldiv_marocchino.sv
// ---------------------------------------------------------------------------
// mor1kx_muldiv_marocchino
//
// Multi-cycle integer multiply / divide unit for the MAROCCHINO execute
// stage. A single operation is in flight at a time. The result is parked
// under a valid/ack handshake so that write-back may take it late.
//
// Multiply:
//   - Full 2W-bit product.
//   - Latency is MUL_STAGES cycles from accept to valid.
// Divide:
//   - Radix-2 restoring divider on operand magnitudes, followed by a sign fixup.
//   - Valid W+1 cycles after accept.
//   - A zero divisor completes one cycle after accept.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush_i          abort whatever is in progress (wins over start/ack)
//   start_i          request strobe, honoured only while idle
//   op_mul_i         request is a multiply
//   op_div_i         request is a divide
//   op_signed_i      operands are two's complement
//   opa_i            multiplicand / dividend
//   opb_i            multiplier / divisor
//   ack_i            consumer takes the result
//   busy_o           unit not idle
//   valid_o          result outputs are valid
//   result_o         product low word / quotient
//   result_hi_o      product high word / remainder
//   div_by_zero_o    divisor was zero (divide only)
// ---------------------------------------------------------------------------
module mor1kx_muldiv_marocchino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int MUL_STAGES           = 2,
  parameter     FEATURE_DIV          = "ENABLED"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            start_i,
  input  logic                            op_mul_i,
  input  logic                            op_div_i,
  input  logic                            op_signed_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] opa_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] opb_i,
  input  logic                            ack_i,
  output logic                            busy_o,
  output logic                            valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] result_hi_o,
  output logic                            div_by_zero_o
);

  localparam int W        = OPTION_OPERAND_WIDTH;
  localparam bit DIV_EN   = (FEATURE_DIV != "NONE");
  localparam int CNT_W    = $clog2(W + 1);
  // Stage marker shift register: one bit per MUL cycle after the accept edge.
  localparam int MUL_SR_W = (MUL_STAGES > 1) ? (MUL_STAGES - 1) : 1;
  localparam int MUL_LAST = (MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0;

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One restoring-division step: shift the next dividend bit (MSB of quo)
  // into the partial remainder, trial-subtract the divisor, and shift the
  // resulting quotient bit into the LSB of quo. Returns {rem, quo}.
  function automatic logic [2*W-1:0] div_step(
    input logic [W-1:0] rem,
    input logic [W-1:0] quo,
    input logic [W-1:0] dsr
  );
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {rem, quo[W-1]};
    diff = sh - {1'b0, dsr};
    if (diff[W]) begin
      div_step = {sh[W-1:0], quo[W-2:0], 1'b0};
    end else begin
      div_step = {diff[W-1:0], quo[W-2:0], 1'b1};
    end
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic                busy_r;
  logic                valid_r;
  logic [W-1:0]        result_r;
  logic [W-1:0]        result_hi_r;
  logic                dbz_r;

  logic [MUL_SR_W-1:0] mul_sr_r;
  logic [2*W-1:0]      mul_prod_r;
  logic [2*W-1:0]      mul_ext_a_s;
  logic [2*W-1:0]      mul_ext_b_s;
  logic [2*W-1:0]      mul_full_s;

  logic [W-1:0]        div_rem_r;
  logic [W-1:0]        div_quo_r;
  logic [W-1:0]        div_dsr_r;
  logic [CNT_W-1:0]    div_cnt_r;
  logic                div_neg_q_r;
  logic                div_neg_r_r;
  logic [W-1:0]        div_mag_a_s;
  logic [W-1:0]        div_mag_b_s;
  logic [2*W-1:0]      div_first_s;
  logic [2*W-1:0]      div_next_s;
  logic [W-1:0]        div_quo_fix_s;
  logic [W-1:0]        div_rem_fix_s;

  logic                mul_acc_s;
  logic                mul_shift_s;
  logic                div_acc_s;
  logic                div_iter_s;
  logic                div_fix_s;
  logic                res_load_s;
  logic [W-1:0]        res_lo_s;
  logic [W-1:0]        res_hi_s;
  logic                res_dbz_s;

  // Sign/zero-extend to 2W bits; the truncated 2W product is then correct
  // for both signed and unsigned operands.
  assign mul_ext_a_s = op_signed_i ? {{W{opa_i[W-1]}}, opa_i} : {ZERO_W, opa_i};
  assign mul_ext_b_s = op_signed_i ? {{W{opb_i[W-1]}}, opb_i} : {ZERO_W, opb_i};
  assign mul_full_s  = mul_ext_a_s * mul_ext_b_s;

  // Operand magnitudes. The most negative value maps onto itself, which
  // read as unsigned is exactly its magnitude.
  assign div_mag_a_s = (op_signed_i && opa_i[W-1]) ? (ZERO_W - opa_i) : opa_i;
  assign div_mag_b_s = (op_signed_i && opb_i[W-1]) ? (ZERO_W - opb_i) : opb_i;

  // The quotient MSB is produced on the accept edge. This leaves W-1 steps
  // plus one fixup cycle in DIV.
  assign div_first_s   = div_step(ZERO_W, div_mag_a_s, div_mag_b_s);
  assign div_next_s    = div_step(div_rem_r, div_quo_r, div_dsr_r);
  assign div_quo_fix_s = div_neg_q_r ? (ZERO_W - div_quo_r) : div_quo_r;
  assign div_rem_fix_s = div_neg_r_r ? (ZERO_W - div_rem_r) : div_rem_r;

  // Next-state decode plus datapath strobes and result-load selection.
  always_comb begin
    state_nxt_s = state_r;
    mul_acc_s   = 1'b0;
    mul_shift_s = 1'b0;
    div_acc_s   = 1'b0;
    div_iter_s  = 1'b0;
    div_fix_s   = 1'b0;
    res_load_s  = 1'b0;
    res_lo_s    = ZERO_W;
    res_hi_s    = ZERO_W;
    res_dbz_s   = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && op_mul_i && !op_div_i) begin
            mul_acc_s = 1'b1;
            if (MUL_STAGES == 1) begin
              state_nxt_s = ST_DONE;
              res_load_s  = 1'b1;
              res_lo_s    = mul_full_s[W-1:0];
              res_hi_s    = mul_full_s[2*W-1:W];
            end else begin
              state_nxt_s = ST_MUL;
            end
          end else if (DIV_EN && start_i && op_div_i && !op_mul_i) begin
            if (opb_i == ZERO_W) begin
              state_nxt_s = ST_DONE;
              res_load_s  = 1'b1;
              res_lo_s    = ZERO_W;
              res_hi_s    = opa_i;
              res_dbz_s   = 1'b1;
            end else begin
              div_acc_s   = 1'b1;
              state_nxt_s = ST_DIV;
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_sr_r[MUL_LAST]) begin
            state_nxt_s = ST_DONE;
            res_load_s  = 1'b1;
            res_lo_s    = mul_prod_r[W-1:0];
            res_hi_s    = mul_prod_r[2*W-1:W];
          end else begin
            mul_shift_s = 1'b1;
            state_nxt_s = ST_MUL;
          end
        end
        ST_DIV: begin
          // Counter W..2: remaining quotient bits; counter 1: sign fixup.
          if (div_cnt_r == CNT_W'(1)) begin
            div_fix_s   = 1'b1;
            state_nxt_s = ST_DONE;
            res_load_s  = 1'b1;
            res_lo_s    = div_quo_fix_s;
            res_hi_s    = div_rem_fix_s;
          end else begin
            div_iter_s  = 1'b1;
            state_nxt_s = ST_DIV;
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered status flags, derived from the next state so that
  // busy_o/valid_o never depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Result registers: written only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= ZERO_W;
      result_hi_r <= ZERO_W;
      dbz_r       <= 1'b0;
    end else if (res_load_s) begin
      result_r    <= res_lo_s;
      result_hi_r <= res_hi_s;
      dbz_r       <= res_dbz_s;
    end
  end

  // Multiplier product holding register and stage marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_prod_r <= {(2*W){1'b0}};
      mul_sr_r   <= {MUL_SR_W{1'b0}};
    end else if (flush_i) begin
      mul_sr_r   <= {MUL_SR_W{1'b0}};
    end else if (mul_acc_s) begin
      mul_prod_r <= mul_full_s;
      mul_sr_r   <= MUL_SR_W'(1);
    end else if (mul_shift_s) begin
      mul_sr_r   <= mul_sr_r << 1;
    end else if (res_load_s) begin
      mul_sr_r   <= {MUL_SR_W{1'b0}};
    end
  end

  // Divider partial remainder / quotient shift registers and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_rem_r   <= ZERO_W;
      div_quo_r   <= ZERO_W;
      div_dsr_r   <= ZERO_W;
      div_cnt_r   <= {CNT_W{1'b0}};
      div_neg_q_r <= 1'b0;
      div_neg_r_r <= 1'b0;
    end else if (flush_i) begin
      div_cnt_r   <= {CNT_W{1'b0}};
    end else if (div_acc_s) begin
      div_rem_r   <= div_first_s[2*W-1:W];
      div_quo_r   <= div_first_s[W-1:0];
      div_dsr_r   <= div_mag_b_s;
      div_cnt_r   <= CNT_W'(W);
      div_neg_q_r <= op_signed_i && (opa_i[W-1] ^ opb_i[W-1]);
      div_neg_r_r <= op_signed_i && opa_i[W-1];
    end else if (div_iter_s) begin
      div_rem_r   <= div_next_s[2*W-1:W];
      div_quo_r   <= div_next_s[W-1:0];
      div_cnt_r   <= div_cnt_r - CNT_W'(1);
    end else if (div_fix_s) begin
      div_cnt_r   <= div_cnt_r - CNT_W'(1);
    end
  end

  assign busy_o        = busy_r;
  assign valid_o       = valid_r;
  assign result_o      = result_r;
  assign result_hi_o   = result_hi_r;
  assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_mor1kx_muldiv_marocchino.sv
// ---------------------------------------------------------------------------
// Directed bench for mor1kx_muldiv_marocchino (W=32, MUL_STAGES=2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mor1kx_muldiv_marocchino;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        start_i = 1'b0;
  logic        op_mul_i = 1'b0;
  logic        op_div_i = 1'b0;
  logic        op_signed_i = 1'b0;
  logic [31:0] opa_i = 32'd0;
  logic [31:0] opb_i = 32'd0;
  logic        ack_i = 1'b0;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [31:0] result_hi_o;
  logic        div_by_zero_o;

  int total = 0;
  int bad   = 0;
  int lat;

  mor1kx_muldiv_marocchino #(
    .OPTION_OPERAND_WIDTH(32),
    .MUL_STAGES(2),
    .FEATURE_DIV("ENABLED")
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .start_i(start_i),
    .op_mul_i(op_mul_i),
    .op_div_i(op_div_i),
    .op_signed_i(op_signed_i),
    .opa_i(opa_i),
    .opb_i(opb_i),
    .ack_i(ack_i),
    .busy_o(busy_o),
    .valid_o(valid_o),
    .result_o(result_o),
    .result_hi_o(result_hi_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request, then wait (bounded) for valid_o.
  // lat = number of cycles from the request cycle to the first valid cycle.
  task automatic issue(input logic mul, input logic div, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b, output int l);
    op_mul_i    = mul;
    op_div_i    = div;
    op_signed_i = sgn;
    opa_i       = a;
    opb_i       = b;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    l = 1;
    while (!valid_o && l < 200) begin
      tick();
      l++;
    end
  endtask

  // Acknowledge for one cycle and confirm the unit is idle afterwards.
  task automatic take(input string tag);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk({tag, "_valid_after_ack"}, {63'd0, valid_o}, 64'd0);
    chk({tag, "_busy_after_ack"}, {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_valid", {63'd0, valid_o}, 64'd0);
    chk("reset_result", {result_hi_o, result_o}, 64'd0);
    chk("reset_dbz", {63'd0, div_by_zero_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Unsigned multiply: FFFFFFFF * FFFFFFFF, valid at T+2
    op_mul_i = 1'b1; op_div_i = 1'b0; op_signed_i = 1'b0;
    opa_i = 32'hFFFF_FFFF; opb_i = 32'hFFFF_FFFF; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("umul_busy_t1", {63'd0, busy_o}, 64'd1);
    chk("umul_valid_t1", {63'd0, valid_o}, 64'd0);
    tick();
    chk("umul_valid_t2", {63'd0, valid_o}, 64'd1);
    chk("umul_result", {result_hi_o, result_o}, 64'hFFFF_FFFE_0000_0001);
    chk("umul_dbz", {63'd0, div_by_zero_o}, 64'd0);

    // Back-pressure for 20 cycles with start pulses that must be ignored
    for (int i = 0; i < 20; i++) begin
      start_i  = i[0];
      op_mul_i = 1'b1;
      opa_i    = 32'd3 + i;
      opb_i    = 32'd5;
      tick();
      chk("hold_valid", {63'd0, valid_o}, 64'd1);
      chk("hold_result", {result_hi_o, result_o}, 64'hFFFF_FFFE_0000_0001);
    end
    start_i = 1'b0;
    take("umul");

    // Signed multiply: -3 * 5 = -15
    issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, lat);
    chk("smul_latency", 64'(lat), 64'd2);
    chk("smul_result", {result_hi_o, result_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    take("smul");

    // Signed divide: -7 / 2 -> q=-3, r=-1, valid at T+33
    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("sdiv_latency", 64'(lat), 64'd33);
    chk("sdiv_result", {result_hi_o, result_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("sdiv_dbz", {63'd0, div_by_zero_o}, 64'd0);
    take("sdiv");

    // Signed divide: 7 / -2 -> q=-3, r=1
    issue(1'b0, 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    chk("sdiv2_result", {result_hi_o, result_o}, 64'h0000_0001_FFFF_FFFD);
    take("sdiv2");

    // Unsigned divide: 100 / 7 -> q=14, r=2
    issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, lat);
    chk("udiv_latency", 64'(lat), 64'd33);
    chk("udiv_result", {result_hi_o, result_o}, 64'h0000_0002_0000_000E);
    take("udiv");

    // Unsigned divide with top-bit dividend: FFFFFFFF / 16 -> q=0FFFFFFF, r=F
    issue(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd16, lat);
    chk("udiv_big_result", {result_hi_o, result_o}, 64'h0000_000F_0FFF_FFFF);
    take("udiv_big");

    // Divide by zero: fast path, valid at T+1
    issue(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'd0, lat);
    chk("dbz_latency", 64'(lat), 64'd1);
    chk("dbz_result", {result_hi_o, result_o}, 64'h0000_1234_0000_0000);
    chk("dbz_flag", {63'd0, div_by_zero_o}, 64'd1);
    take("dbz");

    // Signed overflow: 0x80000000 / -1 -> q=0x80000000, r=0
    issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("ovf_latency", 64'(lat), 64'd33);
    chk("ovf_result", {result_hi_o, result_o}, 64'h0000_0000_8000_0000);
    chk("ovf_dbz", {63'd0, div_by_zero_o}, 64'd0);
    // ack with a simultaneous start: start must be ignored (bubble cycle)
    op_mul_i = 1'b1; op_div_i = 1'b0; start_i = 1'b1;
    take("ovf");
    start_i = 1'b0;
    tick();
    chk("bubble_busy", {63'd0, busy_o}, 64'd0);

    // Flush at T+10 of a divide with start_i in the same cycle
    op_mul_i = 1'b0; op_div_i = 1'b1; op_signed_i = 1'b0;
    opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("flush_pre_valid", {63'd0, valid_o}, 64'd0);
    end
    chk("flush_pre_busy", {63'd0, busy_o}, 64'd1);
    flush_i = 1'b1; start_i = 1'b1; op_mul_i = 1'b1; op_div_i = 1'b0;
    tick();
    flush_i = 1'b0; start_i = 1'b0;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_valid", {63'd0, valid_o}, 64'd0);
    // New mul accepted immediately after the flush
    issue(1'b1, 1'b0, 1'b0, 32'd6, 32'd7, lat);
    chk("postflush_latency", 64'(lat), 64'd2);
    chk("postflush_result", {result_hi_o, result_o}, 64'd42);
    take("postflush");

    // Bad requests in IDLE: both ops, neither op, lone ack
    op_mul_i = 1'b1; op_div_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("both_ops_busy", {63'd0, busy_o}, 64'd0);
    op_mul_i = 1'b0; op_div_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("no_op_busy", {63'd0, busy_o}, 64'd0);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("idle_ack_valid", {63'd0, valid_o}, 64'd0);
    chk("idle_result_kept", {result_hi_o, result_o}, 64'd42);

    // Reset in the middle of a divide
    op_mul_i = 1'b0; op_div_i = 1'b1;
    opa_i = 32'd500; opb_i = 32'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {63'd0, busy_o}, 64'd0);
    chk("midrst_valid", {63'd0, valid_o}, 64'd0);
    chk("midrst_result", {result_hi_o, result_o}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("midrst_no_valid", {63'd0, valid_o}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
